// File: rtl/isdu_gen2.sv
// LC-3 sequencer/decoder: Moore FSM, every control decoded from the registered state (one-cycle latency).
// No backpressure; SRAM access states stretch via a shared wait counter, PAUSE holds until Continue toggles.
module isdu_gen2 #(
    parameter int MEM_WAIT     = 2,
    parameter int PAUSE_EN     = 1,
    parameter int ILLEGAL_HALT = 0,
    parameter int CNT_W        = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             Continue,
    input  logic [3:0]       Opcode,
    input  logic             IR_5,
    input  logic             IR_11,
    input  logic             BEN,
    output logic             LD_MAR,
    output logic             LD_MDR,
    output logic             LD_IR,
    output logic             LD_BEN,
    output logic             LD_CC,
    output logic             LD_REG,
    output logic             LD_PC,
    output logic             LD_LED,
    output logic             GatePC,
    output logic             GateMDR,
    output logic             GateALU,
    output logic             GateMARMUX,
    output logic [1:0]       PCMUX,
    output logic             DRMUX,
    output logic             SR1MUX,
    output logic             SR2MUX,
    output logic             ADDR1MUX,
    output logic [1:0]       ADDR2MUX,
    output logic [1:0]       ALUK,
    output logic             Mem_OE,
    output logic             Mem_WE,
    output logic [CNT_W-1:0] Retired,
    output logic             Halted_o
);

    typedef enum logic [4:0] {
        HALTED, S_18, RD_F, S_35, S_32,
        S_01, S_5, S_9, S_14, S_0, S_22,
        S_2, S_3, S_6, S_7, RD_X, S_27, S_23, WR,
        S_4, S_21, S_12, PAUSE_1, PAUSE_2
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

    state_t     state;
    state_t     next_state;
    logic [3:0] wait_cnt;
    logic       in_mem;
    logic       mem_done;

    assign in_mem   = (state == RD_F) || (state == RD_X) || (state == WR);
    assign mem_done = (wait_cnt == WAIT_LAST);

    // Counter is zero whenever outside an access state, so entry always starts from 0.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= HALTED;
            wait_cnt <= 4'd0;
            Retired  <= '0;
        end else begin
            state    <= next_state;
            wait_cnt <= (in_mem && !mem_done) ? wait_cnt + 4'd1 : 4'd0;
            if (next_state == S_18 && state != HALTED)
                Retired <= Retired + CNT_W'(1);
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            HALTED:  if (Run) next_state = S_18;
            S_18:    next_state = RD_F;
            RD_F:    if (mem_done) next_state = S_35;
            S_35:    next_state = S_32;
            S_32: begin
                case (Opcode)
                    4'b0001: next_state = S_01;
                    4'b0101: next_state = S_5;
                    4'b1001: next_state = S_9;
                    4'b0110: next_state = S_6;
                    4'b0111: next_state = S_7;
                    4'b0010: next_state = S_2;
                    4'b0011: next_state = S_3;
                    4'b1110: next_state = S_14;
                    4'b0100: next_state = S_4;
                    4'b1100: next_state = S_12;
                    4'b0000: next_state = S_0;
                    4'b1101: next_state = (PAUSE_EN != 0) ? PAUSE_1 : S_18;
                    default: next_state = (ILLEGAL_HALT != 0) ? HALTED : S_18;
                endcase
            end
            S_0:     next_state = BEN ? S_22 : S_18;
            S_2, S_6: next_state = RD_X;
            RD_X:    if (mem_done) next_state = S_27;
            S_3, S_7: next_state = S_23;
            S_23:    next_state = WR;
            WR:      if (mem_done) next_state = S_18;
            S_4:     next_state = S_21;
            PAUSE_1: if (Continue) next_state = PAUSE_2;
            PAUSE_2: if (!Continue) next_state = S_18;
            default: next_state = S_18;
        endcase
    end

    always_comb begin
        LD_MAR     = 1'b0;
        LD_MDR     = 1'b0;
        LD_IR      = 1'b0;
        LD_BEN     = 1'b0;
        LD_CC      = 1'b0;
        LD_REG     = 1'b0;
        LD_PC      = 1'b0;
        LD_LED     = 1'b0;
        GatePC     = 1'b0;
        GateMDR    = 1'b0;
        GateALU    = 1'b0;
        GateMARMUX = 1'b0;
        PCMUX      = 2'b00;
        DRMUX      = 1'b0;
        SR1MUX     = 1'b0;
        SR2MUX     = 1'b0;
        ADDR1MUX   = 1'b0;
        ADDR2MUX   = 2'b00;
        ALUK       = 2'b00;
        Mem_OE     = 1'b0;
        Mem_WE     = 1'b0;
        Halted_o   = 1'b0;
        case (state)
            HALTED: Halted_o = 1'b1;
            S_18: begin
                GatePC = 1'b1;
                LD_MAR = 1'b1;
                LD_PC  = 1'b1;
            end
            RD_F, RD_X: begin
                Mem_OE = 1'b1;
                LD_MDR = mem_done;
            end
            S_35: begin
                GateMDR = 1'b1;
                LD_IR   = 1'b1;
            end
            S_32: LD_BEN = 1'b1;
            S_01, S_5, S_9: begin
                SR1MUX  = 1'b1;
                DRMUX   = 1'b1;
                SR2MUX  = (state == S_9) ? 1'b0 : IR_5;
                GateALU = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                ALUK    = (state == S_5) ? 2'b10 : (state == S_9) ? 2'b01 : 2'b00;
            end
            S_14: begin
                ADDR2MUX   = 2'b10;
                GateMARMUX = 1'b1;
                DRMUX      = 1'b1;
                LD_REG     = 1'b1;
                LD_CC      = 1'b1;
            end
            S_22: begin
                ADDR2MUX = 2'b10;
                PCMUX    = 2'b01;
                LD_PC    = 1'b1;
            end
            S_6, S_7: begin
                GateMARMUX = 1'b1;
                ADDR1MUX   = 1'b1;
                SR1MUX     = 1'b1;
                ADDR2MUX   = 2'b01;
                LD_MAR     = 1'b1;
            end
            S_2, S_3: begin
                GateMARMUX = 1'b1;
                ADDR2MUX   = 2'b10;
                LD_MAR     = 1'b1;
            end
            S_27: begin
                GateMDR = 1'b1;
                DRMUX   = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
            end
            // Store data comes from SR (IR[11:9]) passed through the address adder with zero offset.
            S_23: begin
                ADDR1MUX   = 1'b1;
                GateMARMUX = 1'b1;
                LD_MDR     = 1'b1;
            end
            WR: Mem_WE = 1'b1;
            S_4: begin
                GatePC = 1'b1;
                LD_REG = 1'b1;
            end
            S_21: begin
                if (IR_11) begin
                    ADDR2MUX = 2'b11;
                end else begin
                    ADDR1MUX = 1'b1;
                    SR1MUX   = 1'b1;
                end
                PCMUX = 2'b01;
                LD_PC = 1'b1;
            end
            S_12: begin
                ADDR1MUX = 1'b1;
                SR1MUX   = 1'b1;
                PCMUX    = 2'b01;
                LD_PC    = 1'b1;
            end
            PAUSE_1, PAUSE_2: LD_LED = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_isdu_gen2.sv
// Directed bench: three isdu_gen2 instances (MEM_WAIT 2/0/5, pause/illegal variants) share stimulus.
module tb_isdu_gen2;

    localparam int B_LD_MAR = 0,  B_LD_MDR = 1,  B_LD_IR = 2,  B_LD_BEN = 3;
    localparam int B_LD_CC  = 4,  B_LD_REG = 5,  B_LD_PC = 6,  B_LD_LED = 7;
    localparam int B_GPC    = 8,  B_GMDR   = 9,  B_GALU  = 10, B_GMAR   = 11;
    localparam int B_DRMUX  = 14, B_SR1MUX = 15, B_SR2MUX = 16, B_A1MUX = 17;
    localparam int B_OE     = 22, B_WE     = 23, B_HALT  = 24;

    localparam logic [24:0] ONE = 25'd1;
    localparam logic [24:0] W_HALT  = ONE << B_HALT;
    localparam logic [24:0] W_S18   = (ONE << B_GPC) | (ONE << B_LD_MAR) | (ONE << B_LD_PC);
    localparam logic [24:0] W_OE    = ONE << B_OE;
    localparam logic [24:0] W_OEMDR = (ONE << B_OE) | (ONE << B_LD_MDR);
    localparam logic [24:0] W_S35   = (ONE << B_GMDR) | (ONE << B_LD_IR);
    localparam logic [24:0] W_S32   = ONE << B_LD_BEN;
    localparam logic [24:0] W_S01   = (ONE << B_SR1MUX) | (ONE << B_DRMUX) | (ONE << B_GALU)
                                    | (ONE << B_LD_REG) | (ONE << B_LD_CC);
    localparam logic [24:0] W_S7    = (ONE << B_GMAR) | (ONE << B_A1MUX) | (ONE << B_SR1MUX)
                                    | (25'd1 << 18) | (ONE << B_LD_MAR);
    localparam logic [24:0] W_S23   = (ONE << B_A1MUX) | (ONE << B_GMAR) | (ONE << B_LD_MDR);
    localparam logic [24:0] W_WE    = ONE << B_WE;
    localparam logic [24:0] W_S22   = (25'd2 << 18) | (25'd1 << 12) | (ONE << B_LD_PC);
    localparam logic [24:0] W_S4    = (ONE << B_GPC) | (ONE << B_LD_REG);
    localparam logic [24:0] W_S21J  = (25'd3 << 18) | (25'd1 << 12) | (ONE << B_LD_PC);
    localparam logic [24:0] W_LED   = ONE << B_LD_LED;

    logic       clk;
    logic       rst;
    logic       run;
    logic       cont;
    logic [3:0] opcode;
    logic       ir_5;
    logic       ir_11;
    logic       ben;

    wire [2:0][24:0] ctl;
    wire [2:0][15:0] ret;

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    genvar g;
    for (g = 0; g < 3; g++) begin : gd
        localparam int MW = (g == 0) ? 2 : (g == 1) ? 0 : 5;
        localparam int PE = (g == 2) ? 0 : 1;
        localparam int IH = (g == 2) ? 1 : 0;
        localparam int CW = (g == 2) ? 4 : 16;
        wire [CW-1:0] r;
        assign ret[g] = 16'(r);
        isdu_gen2 #(.MEM_WAIT(MW), .PAUSE_EN(PE), .ILLEGAL_HALT(IH), .CNT_W(CW)) u_dut (
            .Clk(clk), .Reset(rst), .Run(run), .Continue(cont),
            .Opcode(opcode), .IR_5(ir_5), .IR_11(ir_11), .BEN(ben),
            .LD_MAR(ctl[g][0]), .LD_MDR(ctl[g][1]), .LD_IR(ctl[g][2]), .LD_BEN(ctl[g][3]),
            .LD_CC(ctl[g][4]), .LD_REG(ctl[g][5]), .LD_PC(ctl[g][6]), .LD_LED(ctl[g][7]),
            .GatePC(ctl[g][8]), .GateMDR(ctl[g][9]), .GateALU(ctl[g][10]), .GateMARMUX(ctl[g][11]),
            .PCMUX(ctl[g][13:12]), .DRMUX(ctl[g][14]), .SR1MUX(ctl[g][15]), .SR2MUX(ctl[g][16]),
            .ADDR1MUX(ctl[g][17]), .ADDR2MUX(ctl[g][19:18]), .ALUK(ctl[g][21:20]),
            .Mem_OE(ctl[g][22]), .Mem_WE(ctl[g][23]),
            .Retired(r), .Halted_o(ctl[g][24])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst  = 1'b1;
        run  = 1'b0;
        cont = 1'b0;
        ben  = 1'b0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic start;
        run = 1'b1;
        tick;
        run = 1'b0;
    endtask

    task automatic wait_bit(input int idx, input int b, input string tag);
        int n = 0;
        while (ctl[idx][b] !== 1'b1 && n < 60) begin
            tick;
            n++;
        end
        chk(tag, 32'(ctl[idx][b]), 32'd1);
    endtask

    int fo[3], fm[3], fpos[3], to[3], wc[3];
    bit seen_ir[3], done[3];
    int exp_w[3];

    initial begin
        rst = 1'b1; run = 1'b0; cont = 1'b0; ben = 1'b0;
        opcode = 4'b0001; ir_5 = 1'b0; ir_11 = 1'b0;
        exp_w[0] = 3; exp_w[1] = 1; exp_w[2] = 6;

        // ADD R1,R2,R3 with MEM_WAIT=2
        do_reset;
        for (int i = 0; i < 3; i++) begin
            chk("rst_ctl", 32'(ctl[i]), 32'(W_HALT));
            chk("rst_ret", 32'(ret[i]), 32'd0);
        end
        start;
        chk("add_s18", 32'(ctl[0]), 32'(W_S18));
        tick; chk("add_rd1", 32'(ctl[0]), 32'(W_OE));
        tick; chk("add_rd2", 32'(ctl[0]), 32'(W_OE));
        tick; chk("add_rd3", 32'(ctl[0]), 32'(W_OEMDR));
        tick; chk("add_s35", 32'(ctl[0]), 32'(W_S35));
        tick; chk("add_s32", 32'(ctl[0]), 32'(W_S32));
        tick; chk("add_s01", 32'(ctl[0]), 32'(W_S01));
        tick; chk("add_back", 32'(ctl[0]), 32'(W_S18));
        chk("add_ret", 32'(ret[0]), 32'd1);

        // LDR: fetch/read strobe widths for MEM_WAIT 2/0/5
        do_reset;
        opcode = 4'b0110;
        start;
        for (int i = 0; i < 3; i++) begin
            fo[i] = 0; fm[i] = 0; fpos[i] = 0; to[i] = 0; wc[i] = 0;
            seen_ir[i] = 1'b0; done[i] = 1'b0;
        end
        for (int c = 0; c < 40; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (ret[i] != 16'd0) done[i] = 1'b1;
                if (!done[i]) begin
                    if (ctl[i][B_OE]) to[i]++;
                    if (ctl[i][B_WE]) wc[i]++;
                    if (!seen_ir[i]) begin
                        if (ctl[i][B_OE]) fo[i]++;
                        if (ctl[i][B_LD_MDR]) begin
                            fm[i]++;
                            fpos[i] = fo[i];
                        end
                    end
                    if (ctl[i][B_LD_IR]) seen_ir[i] = 1'b1;
                end
            end
            tick;
        end
        for (int i = 0; i < 3; i++) begin
            chk("ldr_done", 32'(done[i]), 32'd1);
            chk("ldr_oe_w", 32'(fo[i]), 32'(exp_w[i]));
            chk("ldr_mdr_n", 32'(fm[i]), 32'd1);
            chk("ldr_mdr_pos", 32'(fpos[i]), 32'(exp_w[i]));
            chk("ldr_oe_tot", 32'(to[i]), 32'(2 * exp_w[i]));
            chk("ldr_no_we", 32'(wc[i]), 32'd0);
        end

        // STR twice, reset lands in the second WR cycle of the second store
        do_reset;
        opcode = 4'b0111;
        start;
        wait_bit(0, B_WE, "str1_we");
        begin
            int n = 0;
            while (ctl[0] !== W_S18 && n < 20) begin tick; n++; end
        end
        chk("str1_ret", 32'(ret[0]), 32'd1);
        wait_bit(0, 18, "str2_s7_seen");
        chk("str2_s7", 32'(ctl[0]), 32'(W_S7));
        tick; chk("str2_s23", 32'(ctl[0]), 32'(W_S23));
        tick; chk("str2_wr1", 32'(ctl[0]), 32'(W_WE));
        tick; chk("str2_wr2", 32'(ctl[0]), 32'(W_WE));
        rst = 1'b1;
        tick;
        chk("str_rst_ctl", 32'(ctl[0]), 32'(W_HALT));
        chk("str_rst_ret", 32'(ret[0]), 32'd0);
        rst = 1'b0;
        tick;
        chk("str_stay_halt", 32'(ctl[0]), 32'(W_HALT));

        // BR not taken then taken
        do_reset;
        opcode = 4'b0000;
        start;
        wait_bit(0, B_LD_BEN, "br0_s32");
        tick; chk("br0_s0", 32'(ctl[0]), 32'd0);
        tick; chk("br0_s18", 32'(ctl[0]), 32'(W_S18));
        chk("br0_ret", 32'(ret[0]), 32'd1);
        ben = 1'b1;
        wait_bit(0, B_LD_BEN, "br1_s32");
        tick; chk("br1_s0", 32'(ctl[0]), 32'd0);
        tick; chk("br1_s22", 32'(ctl[0]), 32'(W_S22));
        tick; chk("br1_s18", 32'(ctl[0]), 32'(W_S18));
        chk("br1_ret", 32'(ret[0]), 32'd2);
        ben = 1'b0;

        // JSR (IR_11=1)
        do_reset;
        opcode = 4'b0100;
        ir_11 = 1'b1;
        start;
        wait_bit(0, B_LD_BEN, "jsr_s32");
        tick; chk("jsr_s4", 32'(ctl[0]), 32'(W_S4));
        tick; chk("jsr_s21", 32'(ctl[0]), 32'(W_S21J));
        tick; chk("jsr_s18", 32'(ctl[0]), 32'(W_S18));
        ir_11 = 1'b0;

        // PSE: inst0 pauses, inst2 (PAUSE_EN=0) treats it as a no-op
        do_reset;
        opcode = 4'b1101;
        start;
        wait_bit(0, B_LD_BEN, "pse_s32");
        tick; chk("pse_p1a", 32'(ctl[0]), 32'(W_LED));
        tick; chk("pse_p1b", 32'(ctl[0]), 32'(W_LED));
        cont = 1'b1;
        tick; chk("pse_p2a", 32'(ctl[0]), 32'(W_LED));
        tick; chk("pse_p2b", 32'(ctl[0]), 32'(W_LED));
        cont = 1'b0;
        tick; chk("pse_exit", 32'(ctl[0]), 32'(W_S18));
        chk("pse_ret", 32'(ret[0]), 32'd1);
        chk("pse_noop_ret", 32'(ret[2]), 32'd1);

        // Illegal opcode: skip on inst0, halt on inst2
        do_reset;
        opcode = 4'b1010;
        start;
        wait_bit(0, B_LD_BEN, "ill0_s32");
        tick; chk("ill0_s18", 32'(ctl[0]), 32'(W_S18));
        chk("ill0_ret", 32'(ret[0]), 32'd1);
        wait_bit(2, B_LD_BEN, "ill2_s32");
        tick; chk("ill2_halt", 32'(ctl[2]), 32'(W_HALT));
        chk("ill2_ret", 32'(ret[2]), 32'd0);
        tick; chk("ill2_stay", 32'(ctl[2]), 32'(W_HALT));

        // 4-bit retired counter wraps 15 -> 0
        do_reset;
        opcode = 4'b1101;
        start;
        begin
            int n = 0;
            while (ret[2] != 16'd15 && n < 400) begin tick; n++; end
        end
        chk("wrap_15", 32'(ret[2]), 32'd15);
        begin
            int n = 0;
            while (ret[2] == 16'd15 && n < 20) begin tick; n++; end
        end
        chk("wrap_0", 32'(ret[2]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
